// File: rtl/key_led_ctrl_if.sv
// Event channel of key_led_ctrl: one granted key press per cycle.
// The master side (key_led_ctrl) drives it and the slave side observes it.
interface key_led_ctrl_if #(
    parameter int N_KEYS = 4
) ();
    localparam int KW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;

    logic          evt_valid;
    logic [KW-1:0] evt_key;
    logic          evt_long;

    modport master (output evt_valid, output evt_key, output evt_long);
    modport slave  (input  evt_valid, input  evt_key, input  evt_long);
endinterface

// File: rtl/key_led_ctrl.sv
// Multi-key debounce, short/long press classification, round-robin event arbiter and per-LED mode control.
// Optional feature macro KEY_LONG_PRESS_EN: long-press detection, BLINK mode and the shared blink timer.
module key_led_ctrl #(
    parameter int          N_KEYS      = 4,
    parameter logic [15:0] DEB_CYCLES  = 16'd50000
`ifdef KEY_LONG_PRESS_EN
    ,
    parameter logic [24:0] LONG_CYCLES = 25'h0A98AC7,
    parameter logic [24:0] BLINK_HALF  = 25'h17D7840
`endif
) (
    input  logic              FPGA_clk,
    input  logic              FPGA_rst_n,
    input  logic [N_KEYS-1:0] KEY,
    output logic [N_KEYS-1:0] LED,
    key_led_ctrl_if.master    evt
);
    localparam int KW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;

    // state      | meaning
    // IDLE       | debounced key released, waiting for a press
    // PRESSED    | debounced key down, hold time not yet long
    // LONG_HELD  | long event already raised, waiting for release
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESSED
`ifdef KEY_LONG_PRESS_EN
        , ST_LONG_HELD
`endif
    } press_e;

    typedef enum logic [1:0] {
        M_OFF,
        M_ON
`ifdef KEY_LONG_PRESS_EN
        , M_BLINK
`endif
    } mode_e;

    logic [N_KEYS-1:0] sync1_q, sync2_q, deb_q;
    logic [15:0]       deb_cnt_q [N_KEYS];
    press_e            state_q   [N_KEYS];
    press_e            state_d   [N_KEYS];
    logic [N_KEYS-1:0] raise;
    logic [N_KEYS-1:0] pend_q, pend_d;
    logic [KW-1:0]     ptr_q, ptr_d, grant_idx;
    logic              grant_any;
    logic [N_KEYS-1:0] grant_vec;
    logic              evt_valid_q;
    logic [KW-1:0]     evt_key_q;
    mode_e             mode_q    [N_KEYS];
    mode_e             mode_d    [N_KEYS];
    logic [N_KEYS-1:0] led_q, led_d;
`ifdef KEY_LONG_PRESS_EN
    logic [24:0]       hold_cnt_q [N_KEYS];
    logic [24:0]       hold_cnt_d [N_KEYS];
    logic [N_KEYS-1:0] raise_long;
    logic [N_KEYS-1:0] pend_long_q, pend_long_d;
    logic              evt_long_q;
    logic [24:0]       blink_cnt_q, blink_cnt_d;
    logic              phase_q, phase_d;
`endif

    function automatic logic [KW-1:0] rr_idx(input logic [KW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_KEYS) s = s - N_KEYS;
        return KW'(s);
    endfunction

    // A level change is accepted only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge FPGA_clk or negedge FPGA_rst_n) begin
        if (!FPGA_rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
            deb_q   <= '1;
            for (int i = 0; i < N_KEYS; i++) deb_cnt_q[i] <= '0;
        end else begin
            sync1_q <= KEY;
            sync2_q <= sync1_q;
            for (int i = 0; i < N_KEYS; i++) begin
                if (sync2_q[i] != deb_q[i]) begin
                    if (deb_cnt_q[i] == DEB_CYCLES - 16'd1) begin
                        deb_q[i]     <= sync2_q[i];
                        deb_cnt_q[i] <= '0;
                    end else begin
                        deb_cnt_q[i] <= deb_cnt_q[i] + 16'd1;
                    end
                end else begin
                    deb_cnt_q[i] <= '0;
                end
            end
        end
    end

    // IDLE is only ever entered with deb_q high, so a low level there is the press edge.
    always_comb begin
        for (int i = 0; i < N_KEYS; i++) begin
            state_d[i] = state_q[i];
            raise[i]   = 1'b0;
`ifdef KEY_LONG_PRESS_EN
            raise_long[i] = 1'b0;
            hold_cnt_d[i] = hold_cnt_q[i];
`endif
            case (state_q[i])
                ST_IDLE: begin
                    if (!deb_q[i]) begin
                        state_d[i] = ST_PRESSED;
`ifdef KEY_LONG_PRESS_EN
                        hold_cnt_d[i] = '0;
`endif
                    end
                end
                ST_PRESSED: begin
`ifdef KEY_LONG_PRESS_EN
                    if (hold_cnt_q[i] != '1) hold_cnt_d[i] = hold_cnt_q[i] + 25'd1;
                    if (hold_cnt_q[i] == LONG_CYCLES) begin
                        raise[i]      = 1'b1;
                        raise_long[i] = 1'b1;
                        state_d[i]    = ST_LONG_HELD;
                    end else if (deb_q[i]) begin
                        raise[i]   = 1'b1;
                        state_d[i] = ST_IDLE;
                    end
`else
                    if (deb_q[i]) begin
                        raise[i]   = 1'b1;
                        state_d[i] = ST_IDLE;
                    end
`endif
                end
`ifdef KEY_LONG_PRESS_EN
                ST_LONG_HELD: begin
                    if (deb_q[i]) state_d[i] = ST_IDLE;
                end
`endif
                default: state_d[i] = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        grant_vec = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            if (!grant_any && pend_q[rr_idx(ptr_q, k)]) begin
                grant_any = 1'b1;
                grant_idx = rr_idx(ptr_q, k);
            end
        end
        if (grant_any) grant_vec[grant_idx] = 1'b1;
        ptr_d = ptr_q;
        if (grant_any) ptr_d = (grant_idx == KW'(N_KEYS - 1)) ? '0 : grant_idx + KW'(1);
    end

    // A raise in the same cycle as a grant wins, so the newer event stays pending.
    always_comb begin
        for (int i = 0; i < N_KEYS; i++) begin
            pend_d[i] = pend_q[i];
`ifdef KEY_LONG_PRESS_EN
            pend_long_d[i] = pend_long_q[i];
`endif
            if (raise[i]) begin
                pend_d[i] = 1'b1;
`ifdef KEY_LONG_PRESS_EN
                pend_long_d[i] = raise_long[i];
`endif
            end else if (grant_vec[i]) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
`ifdef KEY_LONG_PRESS_EN
        blink_cnt_d = blink_cnt_q + 25'd1;
        phase_d     = phase_q;
        if (blink_cnt_q == BLINK_HALF - 25'd1) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
`endif
        for (int i = 0; i < N_KEYS; i++) begin
            mode_d[i] = mode_q[i];
            if (evt_valid_q && (evt_key_q == KW'(i))) begin
`ifdef KEY_LONG_PRESS_EN
                if (evt_long_q) mode_d[i] = (mode_q[i] == M_BLINK) ? M_ON : M_BLINK;
                else            mode_d[i] = (mode_q[i] == M_OFF) ? M_ON : M_OFF;
`else
                mode_d[i] = (mode_q[i] == M_ON) ? M_OFF : M_ON;
`endif
            end
`ifdef KEY_LONG_PRESS_EN
            led_d[i] = (mode_d[i] == M_ON) || ((mode_d[i] == M_BLINK) && phase_d);
`else
            led_d[i] = (mode_d[i] == M_ON);
`endif
        end
    end

    always_ff @(posedge FPGA_clk or negedge FPGA_rst_n) begin
        if (!FPGA_rst_n) begin
            for (int i = 0; i < N_KEYS; i++) begin
                state_q[i] <= ST_IDLE;
                mode_q[i]  <= M_OFF;
`ifdef KEY_LONG_PRESS_EN
                hold_cnt_q[i] <= '0;
`endif
            end
            pend_q      <= '0;
            ptr_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_key_q   <= '0;
            led_q       <= '0;
`ifdef KEY_LONG_PRESS_EN
            pend_long_q <= '0;
            evt_long_q  <= 1'b0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
`endif
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                state_q[i] <= state_d[i];
                mode_q[i]  <= mode_d[i];
`ifdef KEY_LONG_PRESS_EN
                hold_cnt_q[i] <= hold_cnt_d[i];
`endif
            end
            pend_q      <= pend_d;
            ptr_q       <= ptr_d;
            evt_valid_q <= grant_any;
            if (grant_any) evt_key_q <= grant_idx;
            led_q       <= led_d;
`ifdef KEY_LONG_PRESS_EN
            pend_long_q <= pend_long_d;
            evt_long_q  <= grant_any & pend_long_q[grant_idx];
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
`endif
        end
    end

    assign LED           = led_q;
    assign evt.evt_valid = evt_valid_q;
    assign evt.evt_key   = evt_key_q;
`ifdef KEY_LONG_PRESS_EN
    assign evt.evt_long  = evt_long_q;
`else
    assign evt.evt_long  = 1'b0;
`endif

endmodule

// File: tb/tb_key_led_ctrl.sv
// Directed bench for key_led_ctrl: expected events are queued as keys are driven and
// matched in order by an event monitor; LED and timing checks are made inline.
module tb_key_led_ctrl;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key;
    logic [3:0] led;

    key_led_ctrl_if #(.N_KEYS(N)) evt_if ();

    key_led_ctrl #(
        .N_KEYS(N),
        .DEB_CYCLES(16'd4)
`ifdef KEY_LONG_PRESS_EN
        ,
        .LONG_CYCLES(25'd20),
        .BLINK_HALF(25'd8)
`endif
    ) dut (
        .FPGA_clk  (clk),
        .FPGA_rst_n(rst_n),
        .KEY       (key),
        .LED       (led),
        .evt       (evt_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] key;
        logic       lng;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   evt_cyc[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_evt    = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] k, input logic l);
        exp_t e;
        e.key = k;
        e.lng = l;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] m, input int cycles);
        key = key & ~m;
        tick(cycles);
        key = key | m;
    endtask

    task automatic wait_evt(input int max, output int waited);
        waited = 0;
        while (evt_if.evt_valid !== 1'b1 && waited < max) begin
            tick(1);
            waited++;
        end
        check("wait_evt", 32'(evt_if.evt_valid === 1'b1), 1);
    endtask

    // Scoreboard: every observed event must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && evt_if.evt_valid === 1'b1) begin
            n_evt++;
            evt_cyc.push_back(cyc);
            check("evt_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("evt_key", 32'(evt_if.evt_key), 32'(mon_e.key));
                check("evt_long", 32'(evt_if.evt_long), 32'(mon_e.lng));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int base;
        int sz;
        logic prev, v, found;

        key   = '1;
        rst_n = 1'b0;
        tick(3);
        check("rst_led", 32'(led), 0);
        check("rst_evt_valid", 32'(evt_if.evt_valid), 0);
        check("rst_evt_key", 32'(evt_if.evt_key), 0);
        check("rst_evt_long", 32'(evt_if.evt_long), 0);
        rst_n = 1'b1;
        tick(2);

        // Short press on key 1 toggles LED[1] on, then off.
        base = n_evt;
        push_exp(2'd1, 1'b0);
        press(4'b0010, 10);
        wait_evt(30, w);
        check("led1_at_evt", 32'(led[1]), 0);
        tick(1);
        check("led1_on", 32'(led[1]), 1);
        tick(10);
        check("key1_one_evt", n_evt - base, 1);
        push_exp(2'd1, 1'b0);
        press(4'b0010, 10);
        wait_evt(30, w);
        tick(1);
        check("led1_off", 32'(led[1]), 0);
        tick(10);
        check("key1_two_evt", n_evt - base, 2);
        check("leds_after_key1", 32'(led), 0);

        // Glitches shorter than the debounce window are ignored.
        base = n_evt;
        repeat (5) begin
            key[0] = 1'b0;
            tick(3);
            key[0] = 1'b1;
            tick(1);
        end
        tick(20);
        check("glitch_no_evt", n_evt - base, 0);
        check("glitch_led", 32'(led), 0);

`ifdef KEY_LONG_PRESS_EN
        base = n_evt;
        push_exp(2'd2, 1'b1);
        key[2] = 1'b0;
        wait_evt(38, w);
        check("long_evt_while_held", n_evt - base, 1);
        tick(40 - w);
        key[2] = 1'b1;
        tick(20);
        check("long_no_release_evt", n_evt - base, 1);
        prev  = led[2];
        found = 1'b0;
        for (int j = 0; j < 12 && !found; j++) begin
            tick(1);
            if (led[2] !== prev) found = 1'b1;
        end
        check("blink_found", 32'(found), 1);
        for (int j = 0; j < 3; j++) begin
            v = led[2];
            tick(7);
            check("blink_hold", 32'(led[2]), 32'(v));
            tick(1);
            check("blink_toggle", 32'(led[2]), 32'(~v));
        end
        push_exp(2'd2, 1'b1);
        key[2] = 1'b0;
        wait_evt(38, w);
        tick(1);
        for (int j = 0; j < 3; j++) begin
            tick(4);
            check("led2_steady", 32'(led[2]), 1);
        end
        key[2] = 1'b1;
        tick(20);
        check("led2_steady_after_release", 32'(led[2]), 1);
        push_exp(2'd2, 1'b1);
        key[2] = 1'b0;
        wait_evt(38, w);
        key[2] = 1'b1;
        tick(20);
        check("long_three_evt", n_evt - base, 3);
`else
        base = n_evt;
        key[3] = 1'b0;
        tick(40);
        check("held_no_evt", n_evt - base, 0);
        push_exp(2'd3, 1'b0);
        key[3] = 1'b1;
        wait_evt(30, w);
        check("led3_at_evt", 32'(led[3]), 0);
        tick(1);
        check("led3_on", 32'(led[3]), 1);
        tick(10);
        check("held_single_evt", n_evt - base, 1);
`endif

        // Reset while key 1 is mid-press: LEDs clear without waiting for a clock edge.
        key[1] = 1'b0;
        tick(12);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_led", 32'(led), 0);
        check("rst_async_evt", 32'(evt_if.evt_valid), 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        key[1] = 1'b1;
        base   = n_evt;
        tick(30);
        check("post_rst_no_evt", n_evt - base, 0);
        check("post_rst_led", 32'(led), 0);
        push_exp(2'd1, 1'b0);
        press(4'b0010, 10);
        wait_evt(30, w);
        tick(1);
        check("post_rst_led1", 32'(led), 32'h2);

        // Simultaneous releases are served on consecutive cycles in pointer order.
        check("sb_empty_pre_arb", exp_q.size(), 0);
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        check("arb_ptr_start", 32'(dut.ptr_q), 0);
        base = n_evt;
        push_exp(2'd0, 1'b0);
        push_exp(2'd1, 1'b0);
        push_exp(2'd3, 1'b0);
        press(4'b1011, 10);
        wait_evt(30, w);
        tick(5);
        check("arb_count", n_evt - base, 3);
        sz = evt_cyc.size();
        if (sz >= 3) begin
            check("arb_consec_a", evt_cyc[sz-2] - evt_cyc[sz-3], 1);
            check("arb_consec_b", evt_cyc[sz-1] - evt_cyc[sz-2], 1);
        end
        check("arb_ptr_end", 32'(dut.ptr_q), 0);
        check("arb_led", 32'(led), 32'hB);
        check("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
